pulse_period_meter: RTL and testbench

Receive-side counterpart of the team's periodic pulse generator. It synchronizes an asynchronous pulse stream and measures the number of clk cycles between consecutive rising edges. It publishes each measured period with a one-cycle valid strobe and flags periods that do not fit in N bits. It is used to close the loop on generated tick streams, for example to check etch-a-sketch step rates, and to measure externally sourced pulse trains.

---
 rtl/pulse_meter_pkg.sv | 13 +
 rtl/sync_edge_detect.sv | 30 +++
 rtl/pulse_period_meter.sv | 107 ++++++++++
 tb/tb_pulse_period_meter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared types and default widths for the pulse period meter.
package pulse_meter_pkg;

    localparam int unsigned DefaultN          = 8;
    localparam int unsigned DefaultSyncStages = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURING
    } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level and flags its rising edges.
// Reusable for button and other slow asynchronous inputs.
module sync_edge_detect
    import pulse_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus edge-history flop; history tracks every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive rising edges of an asynchronous
// pulse stream; publishes each period with a valid strobe and flags
// intervals too long for N bits with an overflow strobe.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned N           = DefaultN,
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         pulse_in,
    output logic [N-1:0] period,
    output logic         valid,
    output logic         overflow
);

    localparam logic [N-1:0] CntMax = {N{1'b1}};
    localparam logic [N-1:0] CntOne = N'(1);

    meter_state_t state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk (clk),
        .rst (rst),
        .d   (pulse_in),
        .rise(rise)
    );

    // Next-state, counter and output decisions; strobes default low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        ovf_d    = 1'b0;
        if (!ena) begin
            // Disabling discards any interval in progress.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
                ARMED: begin
                    if (rise) begin
                        state_d = MEASURING;
                        cnt_d   = '0;
                    end
                end
                MEASURING: begin
                    if (cnt_q == CntMax) begin
                        // Interval reached 2^N cycles: discard it; an edge
                        // landing here starts the next interval.
                        ovf_d = 1'b1;
                        cnt_d = '0;
                        if (!rise) begin
                            state_d = ARMED;
                        end
                    end else if (rise) begin
                        period_d = cnt_q + CntOne;
                        valid_d  = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: an N=8 and an N=4 instance share one
// stimulus stream; an edge-level reference model pushes expected strobes
// to a scoreboard that is drained as the outputs appear.
module tb_pulse_period_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       pulse_in;
    logic [7:0] period8;
    logic       valid8;
    logic       ovf8;
    logic [3:0] period4;
    logic       valid4;
    logic       ovf4;

    pulse_period_meter #(
        .N          (8),
        .SYNC_STAGES(2)
    ) dut8 (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .pulse_in(pulse_in),
        .period  (period8),
        .valid   (valid8),
        .overflow(ovf8)
    );

    pulse_period_meter #(
        .N          (4),
        .SYNC_STAGES(2)
    ) dut4 (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .pulse_in(pulse_in),
        .period  (period4),
        .valid   (valid4),
        .overflow(ovf4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dut;
        bit ovf;
        int per;
        int cyc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         mode[2];    // 0 idle, 1 armed, 2 measuring
    int         last[2];    // cycle of the edge that opened the interval
    int         shown[2];   // period the DUT should currently present
    int         nw[2] = '{8, 4};
    logic [3:0] hist;       // hist[k] = pulse_in driven k cycles ago

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0d want %0d", tag, cyc, got, want);
        end
    endtask

    task automatic push(input int d, input bit ovf, input int per);
        exp_t x;
        x.dut = d;
        x.ovf = ovf;
        x.per = per;
        x.cyc = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic model_reset();
        hist = '0;
        sb.delete();
        for (int d = 0; d < 2; d++) begin
            mode[d]  = 0;
            last[d]  = 0;
            shown[d] = 0;
        end
    endtask

    // Edge-level reference: decision made in cycle cyc, strobe seen in cyc+1.
    task automatic model(input bit en, input bit e);
        int gap;
        for (int d = 0; d < 2; d++) begin
            if (!en) begin
                mode[d] = 0;
            end else if (mode[d] == 0) begin
                mode[d] = 1;
            end else if (mode[d] == 1) begin
                if (e) begin
                    mode[d] = 2;
                    last[d] = cyc;
                end
            end else begin
                gap = cyc - last[d];
                if (gap == (1 << nw[d])) begin
                    push(d, 1'b1, 0);
                    if (e) last[d] = cyc;
                    else mode[d] = 1;
                end else if (e) begin
                    push(d, 1'b0, gap);
                    last[d] = cyc;
                end
            end
        end
    endtask

    task automatic observe();
        bit   ev[2];
        bit   eo[2];
        exp_t x;
        ev[0] = 1'b0; ev[1] = 1'b0;
        eo[0] = 1'b0; eo[1] = 1'b0;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            x = sb.pop_front();
            if (x.ovf) begin
                eo[x.dut] = 1'b1;
            end else begin
                ev[x.dut]    = 1'b1;
                shown[x.dut] = x.per;
            end
        end
        check("valid8", int'(valid8), int'(ev[0]));
        check("ovf8", int'(ovf8), int'(eo[0]));
        check("period8", int'(period8), shown[0]);
        check("valid4", int'(valid4), int'(ev[1]));
        check("ovf4", int'(ovf4), int'(eo[1]));
        check("period4", int'(period4), shown[1]);
    endtask

    // Inputs change 1 time unit after the edge; outputs sampled on negedge.
    task automatic step(input bit en, input bit p);
        @(posedge clk);
        cyc++;
        #1;
        ena      = en;
        pulse_in = p;
        hist     = {hist[2:0], p};
        model(en, hist[2] & ~hist[3]);
        @(negedge clk);
        observe();
    endtask

    task automatic pulses(input int t, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < t; j++) begin
                step(1'b1, j < hi);
            end
        end
    endtask

    task automatic settle();
        repeat (3) step(1'b1, 1'b0);
    endtask

    task automatic anchor(input string tag, input int want);
        check({tag, "_p8"}, int'(period8), want);
        check({tag, "_p4"}, int'(period4), want);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period8"}, int'(period8), 0);
        check({tag, "_valid8"}, int'(valid8), 0);
        check({tag, "_ovf8"}, int'(ovf8), 0);
        check({tag, "_period4"}, int'(period4), 0);
        check({tag, "_valid4"}, int'(valid4), 0);
        check({tag, "_ovf4"}, int'(ovf4), 0);
    endtask

    // Reset asserted between clock edges must clear outputs immediately.
    task automatic reset_mid();
        @(posedge clk);
        cyc++;
        #2;
        ena      = 1'b0;
        pulse_in = 1'b0;
        rst      = 1'b1;
        #1;
        check_zero("rst_mid");
        model_reset();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b0;
        pulse_in = 1'b0;
        model_reset();
        #2;
        check_zero("por");
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;

        // Steady trains: 5 then retargeted to 9.
        repeat (3) step(1'b1, 1'b0);
        pulses(5, 1, 5);
        pulses(9, 1, 4);
        settle();
        anchor("s1", 9);

        // Wide pulses must not re-trigger; then the fastest square wave.
        pulses(8, 3, 4);
        pulses(2, 1, 6);
        settle();
        anchor("s2", 2);

        // Long gaps overflow the narrow instance and force re-arming.
        pulses(20, 1, 2);
        pulses(6, 1, 3);
        settle();
        anchor("s3", 6);

        // Edges exactly 2^4 apart: overflow and restart from that edge.
        pulses(16, 1, 3);
        pulses(3, 1, 3);
        settle();
        anchor("s4", 3);

        // Drop ena mid-interval; re-enable while pulse_in is already high.
        pulses(7, 1, 2);
        repeat (3) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        pulses(7, 1, 3);
        settle();
        anchor("s5", 7);

        // Asynchronous reset mid-interval, then the first scenario again.
        pulses(5, 1, 2);
        repeat (2) step(1'b1, 1'b0);
        reset_mid();
        repeat (2) step(1'b1, 1'b0);
        pulses(5, 1, 4);
        settle();
        anchor("s6", 5);

        check("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
